present_sbox_driver: RTL and testbench
======================================

PRESENT_SBOX_DRIVER -- requirements
Module: present_sbox_driver

Interface
REQ-001 Parameter LAT, default 3: clock edges from the driver's share registers to valid S-box output shares on y1_i..y3_i.
REQ-002 Parameter DEPTH, default 4: result FIFO entries; DEPTH SHALL be >= LAT+1.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 in_valid / in_ready  in / out  1 / 1  unmasked nibble request handshake.
REQ-006 in_data  in  4  unmasked S-box input.
REQ-007 sh1_o, sh2_o, sh3_o  out  4 each  Boolean shares presented to the masked S-box.
REQ-008 r_o  out  45  fresh masking randomness for the S-box; rs_o  out  8  recycled-randomness input for the S-box.
REQ-009 y1_i, y2_i, y3_i  in  4 each  masked S-box output shares.
REQ-010 out_valid / out_ready  out / in  1 / 1  unmasked result handshake; out_data  out  4.
REQ-011 seed_load  in  1 and seed  in  64: PRNG reseed; present only with PRESENT_DRV_SEED_EN.

Function
REQ-012 PRNG: 64-bit xorshift state s, updated every cycle: s^=s<<13; s^=s>>7; s^=s<<17. The update is unconditional, independent of handshakes.
REQ-013 Bit slices of the current s: m1=s[3:0], m2=s[7:4], r_o=s[52:8], rs_o=s[60:53]. r_o/rs_o are driven directly from the state register.
REQ-014 Accept = in_valid && in_ready; in_ready = (inflight + fifo_count) < DEPTH, where inflight = number of set bits in the tag pipe.
REQ-015 On an accept edge, the share registers load sh1=in_data^m1^m2, sh2=m1, sh3=m2.
REQ-016 On a non-accept edge, the share registers load a fresh sharing of zero: sh1=m1^m2, sh2=m1, sh3=m2. Shares never hold stale values.
REQ-017 Tag pipe: LAT-bit shift register; bit0 loads accept, and the register shifts every edge.
REQ-018 When tag[LAT-1]=1, y1_i^y2_i^y3_i is pushed into the FIFO on that edge.
REQ-019 The FIFO never overflows: the credit rule in REQ-014 guarantees this. A push into a full FIFO is an assertion failure.
REQ-020 Latency: an accept at edge E0 makes the result visible on out_valid/out_data after edge E0+LAT+1 (4 cycles at default), provided the FIFO was empty.
REQ-021 FIFO pop = out_valid && out_ready. A simultaneous push and pop at any count, including full and empty, leaves the count unchanged. Read/write pointers wrap modulo DEPTH.
REQ-022 Ordering: results leave in strict acceptance order.
REQ-023 out_data is held stable while out_valid=1 and out_ready=0.

Reset
REQ-024 While rst_i=0 (asynchronous assert): in_ready=0, out_valid=0, out_data=0, share registers=0, tag pipe=0, FIFO empty, s=DEFAULT_SEED (0x0123456789ABCDEF).
REQ-025 in_ready SHALL be 1 on the first edge after rst_i deasserts.
REQ-026 A reset during operation discards all in-flight and buffered results; no stale result may appear after release.

Configuration
REQ-027 Macro PRESENT_DRV_SEED_EN defined: seed_load=1 loads s=seed at the next edge, taking priority over the REQ-012 update.
REQ-028 With PRESENT_DRV_SEED_EN, seed==0 loads DEFAULT_SEED instead, since the all-zero state is forbidden.
REQ-029 Macro PRESENT_DRV_SEED_EN undefined: the seed ports are absent, and s starts from DEFAULT_SEED and free-runs.

Structure
REQ-030 Package present_drv_pkg holds: DEFAULT_SEED; the xorshift shift constants 13/7/17; the randomness slice bounds; the unmasked PRESENT S-box table C56B90AD3EF84712 for bench reference.
REQ-031 The FIFO is one sub-module, present_drv_fifo (parameter DEPTH, width 4, async active-low reset). All other logic stays in present_sbox_driver.

Verification
REQ-032 Check table and latency: after reset, feed in_data=0,1,5,F back-to-back with out_ready=1. out_data SHALL be C,5,0,2, with the first out_valid 4 cycles after the first accept.
REQ-033 Check credit limit: hold out_ready=0 and in_valid=1. Exactly 4 accepts occur, then in_ready=0; out_data=C, 5, 0 and 2 drain in order once out_ready=1.
REQ-034 Check full-FIFO push/pop: with the FIFO full, pulse out_ready for 1 cycle. Exactly one new accept follows, count stays <= 4, and order is preserved.
REQ-035 Check mid-stream reset: assert rst_i=0 with 3 requests in flight. out_valid=0 immediately, and no result appears for 6 cycles after release without new input.
REQ-036 Check reseed (PRESENT_DRV_SEED_EN): seed_load with seed=0 gives s=DEFAULT_SEED at the next edge. Check the share registers: sh2/sh3 equal that cycle's m1/m2, and sh1^sh2^sh3=in_data on accept or 0 when idle.

Source files
------------

// File: rtl/present_drv_pkg.sv
// Shared constants for the PRESENT S-box driver: PRNG seed and shifts, randomness slice
// bounds, share bundle type and the unmasked S-box table.
package present_drv_pkg;

  typedef logic [3:0] nibble_t;

  typedef struct packed {
    nibble_t sh1;
    nibble_t sh2;
    nibble_t sh3;
  } share_t;

  localparam logic [63:0] DEFAULT_SEED = 64'h0123_4567_89AB_CDEF;

  localparam int XS_SHL_A = 13;
  localparam int XS_SHR_B = 7;
  localparam int XS_SHL_C = 17;

  localparam int M1_LSB = 0;
  localparam int M2_LSB = 4;
  localparam int R_LSB  = 8;
  localparam int R_MSB  = 52;
  localparam int RS_LSB = 53;
  localparam int RS_MSB = 60;
  localparam int R_W    = R_MSB - R_LSB + 1;
  localparam int RS_W   = RS_MSB - RS_LSB + 1;

  // Entry 0 sits in the top nibble.
  localparam logic [63:0] SBOX_TABLE = 64'hC56B_90AD_3EF8_4712;

  function automatic logic [63:0] xorshift64(input logic [63:0] s);
    logic [63:0] t;
    t = s ^ (s << XS_SHL_A);
    t = t ^ (t >> XS_SHR_B);
    t = t ^ (t << XS_SHL_C);
    return t;
  endfunction

  function automatic nibble_t sbox_lookup(input nibble_t x);
    return SBOX_TABLE[63 - 4 * int'(x) -: 4];
  endfunction

endpackage

// File: rtl/present_sbox_driver_if.sv
// Request, share, randomness and result signals between the driver (slave) and its user
// plus masked S-box (master).
interface present_sbox_driver_if;
  import present_drv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  nibble_t         in_data;
  nibble_t         sh1_o;
  nibble_t         sh2_o;
  nibble_t         sh3_o;
  logic [R_W-1:0]  r_o;
  logic [RS_W-1:0] rs_o;
  nibble_t         y1_i;
  nibble_t         y2_i;
  nibble_t         y3_i;
  logic            out_valid;
  logic            out_ready;
  nibble_t         out_data;

  modport slave (
    input  in_valid, in_data, out_ready, y1_i, y2_i, y3_i,
    output in_ready, out_valid, out_data, sh1_o, sh2_o, sh3_o, r_o, rs_o
  );

  modport master (
    output in_valid, in_data, out_ready, y1_i, y2_i, y3_i,
    input  in_ready, out_valid, out_data, sh1_o, sh2_o, sh3_o, r_o, rs_o
  );
endinterface

// File: rtl/present_drv_fifo.sv
// Result FIFO: circular buffer with the head entry read combinationally, so a push is
// visible on the output after the pushing edge.
module present_drv_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       rd_en_i,
  output logic [W-1:0]               rd_data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q;
  logic          pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid_o   = (count_q != '0);
  assign pop       = rd_en_i && valid_o;
  assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o   = count_q;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + LW'(wr_en_i) - LW'(pop);
    end
  end

  // When full, a write only happens together with a pop, so the slot being read is free.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_i)
    !(wr_en_i && (count_q == LW'(DEPTH)) && !pop));

endmodule

// File: rtl/present_sbox_driver.sv
// PRESENT S-box driver: splits nibbles into three Boolean shares, tracks them through an
// external masked S-box and returns unmasked results in order. Reseed port: PRESENT_DRV_SEED_EN.
module present_sbox_driver
  import present_drv_pkg::*;
#(
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_i,
`ifdef PRESENT_DRV_SEED_EN
  input  logic        seed_load,
  input  logic [63:0] seed,
`endif
  present_sbox_driver_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(DEPTH + LAT + 2);

  logic [63:0]    s_q, s_d;
  share_t         sh_q, sh_d;
  logic [LAT-1:0] tag_q, tag_d;
  logic           res_vld_q;
  nibble_t        res_q;
  logic [LW-1:0]  fifo_level;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  credit;
  logic           accept;
  nibble_t        m1, m2;

  assign m1 = s_q[M1_LSB +: 4];
  assign m2 = s_q[M2_LSB +: 4];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + CW'(tag_q[i]);
  end

  // Every result owed to the FIFO holds a credit from accept until it is popped.
  assign credit       = inflight + CW'(fifo_level) + CW'(res_vld_q);
  assign bus.in_ready = rst_i && (credit < CW'(DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
`ifdef PRESENT_DRV_SEED_EN
    if (seed_load) s_d = (seed == 64'd0) ? DEFAULT_SEED : seed;
    else           s_d = xorshift64(s_q);
`else
    s_d = xorshift64(s_q);
`endif
  end

  always_comb begin
    sh_d.sh1 = (accept ? bus.in_data : 4'h0) ^ m1 ^ m2;
    sh_d.sh2 = m1;
    sh_d.sh3 = m2;
  end

  assign tag_d[0] = accept;
  for (genvar gi = 1; gi < LAT; gi++) begin : g_tag
    assign tag_d[gi] = tag_q[gi-1];
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      s_q       <= DEFAULT_SEED;
      sh_q      <= '0;
      tag_q     <= '0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      s_q       <= s_d;
      sh_q      <= sh_d;
      tag_q     <= tag_d;
      res_vld_q <= tag_q[LAT-1];
      res_q     <= bus.y1_i ^ bus.y2_i ^ bus.y3_i;
    end
  end

  assign bus.sh1_o = sh_q.sh1;
  assign bus.sh2_o = sh_q.sh2;
  assign bus.sh3_o = sh_q.sh3;
  assign bus.r_o   = s_q[R_MSB:R_LSB];
  assign bus.rs_o  = s_q[RS_MSB:RS_LSB];

  present_drv_fifo #(
    .DEPTH (DEPTH),
    .W     (4)
  ) u_fifo (
    .clk       (clk),
    .rst_i     (rst_i),
    .wr_en_i   (res_vld_q),
    .wr_data_i (res_q),
    .rd_en_i   (bus.out_ready),
    .rd_data_o (bus.out_data),
    .valid_o   (bus.out_valid),
    .level_o   (fifo_level)
  );

endmodule

// File: tb/tb_present_sbox_driver.sv
// Scoreboard bench for present_sbox_driver with a behavioural masked S-box on the share side.
module tb_present_sbox_driver;
  import present_drv_pkg::*;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic [3:0] sbox_ref [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [3:0] feed [4] = '{4'h0, 4'h1, 4'h5, 4'hF};

  logic clk   = 1'b0;
  logic rst_i = 1'b0;
  present_sbox_driver_if bus_if ();
`ifdef PRESENT_DRV_SEED_EN
  logic        seed_load = 1'b0;
  logic [63:0] seed      = 64'd0;
`endif

  present_sbox_driver #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_i     (rst_i),
`ifdef PRESENT_DRV_SEED_EN
    .seed_load (seed_load),
    .seed      (seed),
`endif
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int n_out    = 0;
  logic [3:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] prng_next(input logic [63:0] x);
    x = x ^ (x << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction

  // Masked S-box model: LAT register stages counting the driver's share register,
  // output re-split into fresh random shares every cycle.
  logic [3:0] env_pipe [LAT-1];
  logic [3:0] env_ma, env_mb;
  always @(posedge clk) begin
    env_pipe[0] <= sbox_ref[bus_if.sh1_o ^ bus_if.sh2_o ^ bus_if.sh3_o];
    for (int i = 1; i < LAT - 1; i++) env_pipe[i] <= env_pipe[i-1];
    env_ma <= 4'($urandom);
    env_mb <= 4'($urandom);
  end
  assign bus_if.y1_i = env_ma;
  assign bus_if.y2_i = env_mb;
  assign bus_if.y3_i = env_pipe[LAT-2] ^ env_ma ^ env_mb;

  // Reference PRNG state and the unmasked value the shares should encode.
  logic [63:0] s_m, s_prev;
  logic        sh_valid = 1'b0;
  logic        acc_pend = 1'b0;
  logic [3:0]  acc_data = 4'h0;
  logic [3:0]  exp_sum  = 4'h0;
  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      s_m      <= DEFAULT_SEED;
      sh_valid <= 1'b0;
    end else begin
      s_prev   <= s_m;
`ifdef PRESENT_DRV_SEED_EN
      if (seed_load) s_m <= (seed == 64'd0) ? DEFAULT_SEED : seed;
      else           s_m <= prng_next(s_m);
`else
      s_m      <= prng_next(s_m);
`endif
      exp_sum  <= acc_pend ? acc_data : 4'h0;
      sh_valid <= 1'b1;
      cyc      <= cyc + 1;
    end
  end

  // Stimulus side: reset values, share/randomness checks, and scoreboard pushes on accept.
  always @(negedge clk) begin
    if (!rst_i) begin
      exp_q.delete();
      check("rst_in_ready", 64'(bus_if.in_ready), 0);
      check("rst_out_valid", 64'(bus_if.out_valid), 0);
      check("rst_out_data", 64'(bus_if.out_data), 0);
      check("rst_shares", {52'd0, bus_if.sh1_o, bus_if.sh2_o, bus_if.sh3_o}, 0);
      acc_pend <= 1'b0;
    end else begin
      if (sh_valid) begin
        check("sh2_is_m1", 64'(bus_if.sh2_o), 64'(s_prev[3:0]));
        check("sh3_is_m2", 64'(bus_if.sh3_o), 64'(s_prev[7:4]));
        check("share_sum", 64'(bus_if.sh1_o ^ bus_if.sh2_o ^ bus_if.sh3_o), 64'(exp_sum));
      end
      if (bus_if.in_valid && bus_if.in_ready) begin
        exp_q.push_back(sbox_ref[bus_if.in_data]);
        acc_cnt++;
        acc_pend <= 1'b1;
        acc_data <= bus_if.in_data;
      end else begin
        acc_pend <= 1'b0;
      end
    end
    check("r_o", 64'(bus_if.r_o), 64'(s_m[52:8]));
    check("rs_o", 64'(bus_if.rs_o), 64'(s_m[60:53]));
  end

  // Monitor: pops the scoreboard on every transfer and checks output stability under stall.
  logic       hold_pend = 1'b0;
  logic [3:0] hold_val  = 4'h0;
  logic [3:0] exp_d;
  always @(negedge clk) begin
    if (rst_i && bus_if.out_valid) begin
      if (hold_pend) check("out_hold", 64'(bus_if.out_data), 64'(hold_val));
      if (bus_if.out_ready) begin
        hold_pend = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h, required no output", bus_if.out_data);
        end else begin
          exp_d = exp_q.pop_front();
          check("out_data", 64'(bus_if.out_data), 64'(exp_d));
          $display("out #%0d data=%0h expected=%0h", n_out, bus_if.out_data, exp_d);
        end
        n_out++;
      end else begin
        hold_pend = 1'b1;
        hold_val  = bus_if.out_data;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int k = 0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus_if.out_valid) && k < 200) begin
      step();
      k++;
    end
    check("drain_done", 64'(exp_q.size()), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, a0, o0, k;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 4'h0;
    bus_if.out_ready = 1'b0;
    rst_i = 1'b0;
    repeat (3) step();
    rst_i = 1'b1;
    step();
    check("ready_after_rst", 64'(bus_if.in_ready), 1);

    // Table and latency: 0,1,5,F back-to-back.
    bus_if.out_ready = 1'b1;
    o0 = n_out;
    e0 = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = feed[i];
      step();
    end
    bus_if.in_valid = 1'b0;
    k = 0;
    while (!bus_if.out_valid && k < 20) begin
      step();
      k++;
    end
    check("first_out_valid", 64'(bus_if.out_valid), 1);
    check("latency_edges", 64'(cyc - e0), 64'(LAT + 1));
    wait_drain();
    check("table_outputs", 64'(n_out - o0), 4);

    // Random traffic, light then heavy back-pressure.
    for (int p = 0; p < 2; p++) begin
      repeat (300) begin
        bus_if.in_valid  = 1'($urandom_range(0, 1));
        bus_if.in_data   = 4'($urandom);
        bus_if.out_ready = (p == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        step();
      end
      wait_drain();
    end

    // Credit limit with the output stalled.
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b1;
    a0 = acc_cnt;
    o0 = n_out;
    for (int i = 0; i < 12; i++) begin
      bus_if.in_data = feed[i % 4];
      step();
    end
    check("credit_accepts", 64'(acc_cnt - a0), 64'(DEPTH));
    check("credit_in_ready", 64'(bus_if.in_ready), 0);
    repeat (LAT + 2) step();

    // One-cycle pop from a full FIFO lets exactly one new request in.
    bus_if.in_data   = 4'hA;
    a0 = acc_cnt;
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
    repeat (10) step();
    check("full_pop_accepts", 64'(acc_cnt - a0), 1);
    check("full_in_ready", 64'(bus_if.in_ready), 0);
    wait_drain();
    check("credit_outputs", 64'(n_out - o0), 64'(DEPTH + 1));

    // Reset with one buffered result and three in flight.
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 4'($urandom);
    step();
    bus_if.in_valid  = 1'b0;
    repeat (LAT + 2) step();
    check("pre_rst_out_valid", 64'(bus_if.out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 4'($urandom);
      step();
    end
    bus_if.in_valid = 1'b0;
    #1;
    rst_i = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus_if.out_valid), 0);
    check("midrst_in_ready", 64'(bus_if.in_ready), 0);
    check("midrst_out_data", 64'(bus_if.out_data), 0);
    repeat (2) step();
    rst_i = 1'b1;
    bus_if.out_ready = 1'b1;
    repeat (6) begin
      step();
      check("post_rst_quiet", 64'(bus_if.out_valid), 0);
    end

`ifdef PRESENT_DRV_SEED_EN
    begin
      logic [63:0] dseed;
      dseed     = DEFAULT_SEED;
      seed      = 64'd0;
      seed_load = 1'b1;
      step();
      seed_load = 1'b0;
      check("reseed_zero_r", 64'(bus_if.r_o), 64'(dseed[52:8]));
      check("reseed_zero_rs", 64'(bus_if.rs_o), 64'(dseed[60:53]));
    end
`endif

    repeat (200) begin
      bus_if.in_valid  = 1'($urandom_range(0, 1));
      bus_if.in_data   = 4'($urandom);
      bus_if.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    wait_drain();
    check("scoreboard_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
